prefetch_queue: RTL

Instruction prefetch queue that sits directly upstream of the instruction fetch/decode stage. It reads aligned 16-bit words from the memory bus, stores up to `QBYTES` instruction bytes, and presents the byte stream at the decoder's current linear PC. The decoder consumes one or two bytes per cycle. A flush on any control transfer restarts prefetch at a new linear address, including odd-aligned targets.

---
 rtl/prefetch_queue.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction prefetch byte queue between the memory bus and
// the fetch/decode stage. Fetches aligned 16-bit words, buffers up to QBYTES
// bytes and presents the byte stream at the decoder's current linear PC.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   flush, flush_pc   discard queue, restart prefetch at flush_pc (may be odd)
//   pop, pop_word     consume 1 (pop_word=0) or 2 (pop_word=1) bytes at head
//   q_data            {next byte, head byte}; bytes not present read as 8'h00
//   q_cnt             valid bytes in queue, 0..QBYTES
//   head_pc           linear address of q_data[7:0]
//   mem_req, mem_adr  registered word-read request, held until mem_ack
//   mem_ack, mem_dat  read completion and data ([7:0] = even byte)
module prefetch_queue #(
    parameter int unsigned QBYTES   = 6,
    parameter logic [19:0] RESET_PC = 20'hFFFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [19:0] flush_pc,
    input  logic        pop,
    input  logic        pop_word,
    output logic [15:0] q_data,
    output logic [3:0]  q_cnt,
    output logic [19:0] head_pc,
    output logic        mem_req,
    output logic [18:0] mem_adr,
    input  logic        mem_ack,
    input  logic [15:0] mem_dat
);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t      state, state_nx;
    logic [7:0]  qbuf [QBYTES];
    logic [2:0]  rd_ptr, wr_ptr;
    logic [3:0]  cnt, cnt_after;
    logic [19:0] head_r, fetch_adr, fetch_nx;
    logic [18:0] adr_r, adr_nx;
    logic [1:0]  pop_n, wr_n;
    logic        pop_ok, wr_en, space_ok;

    // Pointer advance modulo QBYTES (QBYTES need not be a power of two).
    function automatic logic [2:0] ptr_add(input logic [2:0] p, input logic [1:0] n);
        logic [3:0] s;
        s = {1'b0, p} + {2'b00, n};
        if (s >= 4'(QBYTES))
            s = s - 4'(QBYTES);
        return s[2:0];
    endfunction

    // Datapath quantities for this cycle (flush overrides both pop and write).
    always_comb begin
        pop_ok    = pop && (cnt >= (pop_word ? 4'd2 : 4'd1));
        pop_n     = pop_ok ? (pop_word ? 2'd2 : 2'd1) : 2'd0;
        wr_en     = (state == REQ) && mem_ack && !flush;
        wr_n      = wr_en ? (fetch_adr[0] ? 2'd1 : 2'd2) : 2'd0;
        cnt_after = cnt - {2'b00, pop_n} + {2'b00, wr_n};
        space_ok  = (4'(QBYTES) - cnt_after) >= 4'd2;
    end

    // Bus FSM: next state, next fetch address and next request address.
    always_comb begin
        state_nx = state;
        fetch_nx = fetch_adr;
        adr_nx   = adr_r;
        case (state)
            IDLE: begin
                if (flush) begin
                    fetch_nx = flush_pc;
                    state_nx = REQ;
                end else if (space_ok) begin
                    state_nx = REQ;
                end
                adr_nx = fetch_nx[19:1];
            end
            REQ: begin
                if (flush) begin
                    fetch_nx = flush_pc;
                    // Without an ack the bus cycle in flight must still
                    // complete at the old address; its data is dropped later.
                    if (mem_ack)
                        adr_nx = flush_pc[19:1];
                    else
                        state_nx = DISCARD;
                end else if (mem_ack) begin
                    fetch_nx = fetch_adr + (fetch_adr[0] ? 20'd1 : 20'd2);
                    adr_nx   = fetch_nx[19:1];
                    if (!space_ok)
                        state_nx = IDLE;
                end
            end
            DISCARD: begin
                if (flush)
                    fetch_nx = flush_pc;
                if (mem_ack) begin
                    state_nx = REQ;
                    adr_nx   = fetch_nx[19:1];
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            head_r    <= RESET_PC;
            fetch_adr <= RESET_PC;
            adr_r     <= RESET_PC[19:1];
            for (int unsigned i = 0; i < QBYTES; i++)
                qbuf[i] <= '0;
        end else begin
            state     <= state_nx;
            fetch_adr <= fetch_nx;
            adr_r     <= adr_nx;
            if (flush) begin
                cnt    <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                head_r <= flush_pc;
            end else begin
                cnt    <= cnt_after;
                rd_ptr <= ptr_add(rd_ptr, pop_n);
                head_r <= head_r + {18'd0, pop_n};
                wr_ptr <= ptr_add(wr_ptr, wr_n);
                if (wr_en) begin
                    // Odd fetch address: only the high byte of the word is wanted.
                    if (fetch_adr[0]) begin
                        qbuf[wr_ptr] <= mem_dat[15:8];
                    end else begin
                        qbuf[wr_ptr]                <= mem_dat[7:0];
                        qbuf[ptr_add(wr_ptr, 2'd1)] <= mem_dat[15:8];
                    end
                end
            end
        end
    end

    assign q_cnt   = cnt;
    assign head_pc = head_r;
    assign mem_req = (state != IDLE);
    assign mem_adr = adr_r;
    assign q_data  = {(cnt >= 4'd2) ? qbuf[ptr_add(rd_ptr, 2'd1)] : 8'h00,
                      (cnt != 4'd0) ? qbuf[rd_ptr] : 8'h00};

endmodule
